regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter p_num_pipes, default 2, giving the number of writeback requesters (2..8).
REQ-002 The block SHALL have parameter p_entry_bits, default 32, giving the data width.
REQ-003 The block SHALL have parameter p_num_regs, default 32, giving the register count; AW = $clog2(p_num_regs).
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 The block SHALL have port clk, input, 1, the clock.
REQ-006 The block SHALL have port rst, input, 1, the asynchronous active-low reset.
REQ-007 The block SHALL have port pipe_wen[p_num_pipes], input, 1 each, requester write valid.
REQ-008 The block SHALL have port pipe_waddr[p_num_pipes], input, AW each, requester destination register.
REQ-009 The block SHALL have port pipe_wdata[p_num_pipes], input, p_entry_bits each, requester write data.
REQ-010 The block SHALL have port pipe_ready[p_num_pipes], output, 1 each, high when that requester's write is accepted this cycle.
REQ-011 The block SHALL have ports rf_waddr, output, AW; rf_wdata, output, p_entry_bits; and rf_wen, output, 1; together these drive the register-file write port.
REQ-012 The block SHALL have ports iss_val, input, 1; iss_wen, input, 1; iss_waddr, input, AW; and iss_raddr[2], input, AW each; together these describe the instruction being issued.
REQ-013 The block SHALL have port iss_stall, output, 1, high when the issuing instruction must be held.

Function
REQ-014 The block SHALL keep a round-robin pointer ptr in 0..p_num_pipes-1.
- Among requesters with pipe_wen high, grant exactly one: the first index at or after ptr, wrapping modulo p_num_pipes.
REQ-015 pipe_ready SHALL be combinational.
- High only for the granted index.
- All pipe_ready low when no pipe_wen is high.
REQ-016 A transfer SHALL occur when pipe_wen and pipe_ready are both high.
- On a transfer, ptr becomes (granted index + 1) mod p_num_pipes at the next edge.
- Otherwise ptr holds.
REQ-017 A requester with pipe_wen high and pipe_ready low SHALL hold waddr and wdata stable; the block does not buffer it.
REQ-018 rf_waddr, rf_wdata and rf_wen SHALL be registered, giving exactly 1 cycle from transfer to register-file write.
REQ-019 rf_wen SHALL be high in the cycle after a transfer whose waddr is nonzero, and low otherwise.
- A write to x0 is still granted and consumed.
REQ-020 Sustained throughput SHALL be one write per cycle.
- With all requesters continuously valid, each is granted once every p_num_pipes cycles.

Reset
REQ-021 While rst is low, the block SHALL asynchronously force:
- ptr = 0
- rf_wen = 0, rf_waddr = 0, rf_wdata = 0
- all scoreboard pending bits = 0
REQ-022 A requester held mid-wait across reset SHALL be arbitrated afresh from ptr = 0 after reset deasserts.
- No write is produced during reset.

Configuration
REQ-023 When macro REGFILE_WB_ARB_SCOREBOARD_EN is defined, the block SHALL keep a pending bit for each register 1..p_num_regs-1; x0 is never pending.
REQ-024 With the macro defined, iss_stall SHALL be combinational, equal to iss_val AND any of:
- pending[iss_raddr[0]]
- pending[iss_raddr[1]]
- iss_wen AND pending[iss_waddr]
REQ-025 With the macro defined, pending[iss_waddr] SHALL set at the next edge when iss_val, iss_wen and !iss_stall are high and iss_waddr != 0.
REQ-026 With the macro defined, pending[pipe_waddr] SHALL clear at the next edge on a transfer of that address.
- If set and clear hit the same register in the same cycle, set wins.
REQ-027 Clearing at transfer SHALL let an issue in the following cycle read the register file while rf_wen is high, relying on the register file's same-cycle write forwarding.
REQ-028 Without the macro, the block SHALL:
- keep no pending state
- ignore the iss_* inputs
- tie iss_stall to 0

Verification
REQ-029 Reset: hold rst low, drive pipe_wen = all 1s -> all pipe_ready = 0, rf_wen = 0; after release, pipe 0 is granted first.
REQ-030 Round-robin: 2 pipes continuously valid, pipe0 waddr 5 data 0xA, pipe1 waddr 6 data 0xB -> rf_wen = 1 every cycle, with (rf_waddr, rf_wdata) alternating (5, 0xA), (6, 0xB).
REQ-031 Grant skip: ptr = 1, only pipe0 valid -> pipe0 is granted that cycle and ptr becomes 1.
REQ-032 x0: pipe0 writes waddr 0 data 0xFFFF -> pipe_ready[0] = 1, and next cycle rf_wen = 0.
REQ-033 Scoreboard, macro defined: issue x3 write -> next cycle an issue reading x3 gets iss_stall = 1.
- Then pipe1 transfers x3 -> iss_stall drops the following cycle, with rf_wen = 1 and rf_waddr = 3 in that same cycle.
REQ-034 Scoreboard collision, macro defined: in one cycle pipe0 transfers x7 while an issue writes x7 -> pending[7] = 1 afterwards, and a subsequent read of x7 stalls.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter: N requesters share one register-file write port.
// Define REGFILE_WB_ARB_SCOREBOARD_EN to add per-register pending bits and issue-stall logic.
module regfile_wb_arbiter #(
    parameter int p_num_pipes  = 2,
    parameter int p_entry_bits = 32,
    parameter int p_num_regs   = 32,
    localparam int AW = $clog2(p_num_regs)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [p_num_pipes-1:0]  pipe_wen,
    input  logic [AW-1:0]           pipe_waddr [p_num_pipes],
    input  logic [p_entry_bits-1:0] pipe_wdata [p_num_pipes],
    output logic [p_num_pipes-1:0]  pipe_ready,
    output logic [AW-1:0]           rf_waddr,
    output logic [p_entry_bits-1:0] rf_wdata,
    output logic                    rf_wen,
    input  logic                    iss_val,
    input  logic                    iss_wen,
    input  logic [AW-1:0]           iss_waddr,
    input  logic [AW-1:0]           iss_raddr [2],
    output logic                    iss_stall
);
    localparam int PW = $clog2(p_num_pipes);

    logic [PW-1:0]           ptr;
    logic [PW-1:0]           grant_idx;
    logic                    grant_valid;
    logic [AW-1:0]           grant_waddr;
    logic [p_entry_bits-1:0] grant_wdata;

    // First requesting index at or after ptr wins; nothing is granted while in reset.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (rst) begin
            for (int i = 0; i < p_num_pipes; i++) begin
                if (!grant_valid && pipe_wen[(int'(ptr) + i) % p_num_pipes]) begin
                    grant_valid = 1'b1;
                    grant_idx   = PW'((int'(ptr) + i) % p_num_pipes);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < p_num_pipes; i++) begin
            pipe_ready[i] = grant_valid && (grant_idx == PW'(i));
        end
    end

    assign grant_waddr = pipe_waddr[grant_idx];
    assign grant_wdata = pipe_wdata[grant_idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr      <= '0;
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_wen <= grant_valid && (grant_waddr != '0);
            if (grant_valid) begin
                rf_waddr <= grant_waddr;
                rf_wdata <= grant_wdata;
                if (grant_idx == PW'(p_num_pipes - 1)) begin
                    ptr <= '0;
                end else begin
                    ptr <= grant_idx + 1'b1;
                end
            end
        end
    end

`ifdef REGFILE_WB_ARB_SCOREBOARD_EN
    logic [p_num_regs-1:0] pending;
    logic [p_num_regs-1:0] pending_nxt;

    assign iss_stall = iss_val && (pending[iss_raddr[0]] || pending[iss_raddr[1]] ||
                                   (iss_wen && pending[iss_waddr]));

    // Clear on writeback first so a same-cycle issue to the same register keeps it pending.
    always_comb begin
        pending_nxt = pending;
        if (grant_valid) begin
            pending_nxt[grant_waddr] = 1'b0;
        end
        if (iss_val && iss_wen && !iss_stall && (iss_waddr != '0)) begin
            pending_nxt[iss_waddr] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end
`else
    logic unused_iss;

    assign unused_iss = ^{iss_val, iss_wen, iss_waddr, iss_raddr[0], iss_raddr[1]};
    assign iss_stall  = 1'b0;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (2 pipes, 32x32); scoreboard scenarios
// follow REGFILE_WB_ARB_SCOREBOARD_EN, otherwise iss_stall must stay low.
module tb_regfile_wb_arbiter;
    localparam int NP = 2;
    localparam int EB = 32;
    localparam int NR = 32;
    localparam int AW = 5;

    logic          clk;
    logic          rst;
    logic [NP-1:0] pipe_wen;
    logic [AW-1:0] pipe_waddr [NP];
    logic [EB-1:0] pipe_wdata [NP];
    logic [NP-1:0] pipe_ready;
    logic [AW-1:0] rf_waddr;
    logic [EB-1:0] rf_wdata;
    logic          rf_wen;
    logic          iss_val;
    logic          iss_wen;
    logic [AW-1:0] iss_waddr;
    logic [AW-1:0] iss_raddr [2];
    logic          iss_stall;

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter #(
        .p_num_pipes (NP),
        .p_entry_bits(EB),
        .p_num_regs  (NR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pipe_wen  (pipe_wen),
        .pipe_waddr(pipe_waddr),
        .pipe_wdata(pipe_wdata),
        .pipe_ready(pipe_ready),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .rf_wen    (rf_wen),
        .iss_val   (iss_val),
        .iss_wen   (iss_wen),
        .iss_waddr (iss_waddr),
        .iss_raddr (iss_raddr),
        .iss_stall (iss_stall)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        pipe_wen      = '0;
        pipe_waddr[0] = '0;
        pipe_waddr[1] = '0;
        pipe_wdata[0] = '0;
        pipe_wdata[1] = '0;
        iss_val       = 1'b0;
        iss_wen       = 1'b0;
        iss_waddr     = '0;
        iss_raddr[0]  = '0;
        iss_raddr[1]  = '0;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        pipe_wen      = 2'b11;
        pipe_waddr[0] = 5'd1;
        pipe_waddr[1] = 5'd2;
        pipe_wdata[0] = 32'h100;
        pipe_wdata[1] = 32'h200;
        tick();
        tick();
        checks++;
        if (pipe_ready !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 00", pipe_ready);
        end
        checks++;
        if ({rf_wen, rf_waddr, rf_wdata} !== {1'b0, 5'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset_rf: got wen=%b addr=%0d data=%0h expected 0/0/0", rf_wen, rf_waddr, rf_wdata);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (pipe_ready !== 2'b01) begin
            errors++;
            $display("FAIL reset_first_grant: got %b expected 01", pipe_ready);
        end
        tick();
        checks++;
        if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd1, 32'h100}) begin
            errors++;
            $display("FAIL reset_first_write: got wen=%b addr=%0d data=%0h expected 1/1/100", rf_wen, rf_waddr, rf_wdata);
        end
        checks++;
        if (pipe_ready !== 2'b10) begin
            errors++;
            $display("FAIL reset_second_grant: got %b expected 10", pipe_ready);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]    exp_ready;
        logic [AW-1:0] exp_addr;
        logic [EB-1:0] exp_data;
        apply_reset();
        pipe_wen      = 2'b11;
        pipe_waddr[0] = 5'd5;
        pipe_waddr[1] = 5'd6;
        pipe_wdata[0] = 32'hA;
        pipe_wdata[1] = 32'hB;
        for (int k = 0; k < 6; k++) begin
            #1;
            exp_ready = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_addr  = (k % 2 == 0) ? 5'd5 : 5'd6;
            exp_data  = (k % 2 == 0) ? 32'hA : 32'hB;
            checks++;
            if (pipe_ready !== exp_ready) begin
                errors++;
                $display("FAIL rr_ready[%0d]: got %b expected %b", k, pipe_ready, exp_ready);
            end
            tick();
            checks++;
            if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, exp_addr, exp_data}) begin
                errors++;
                $display("FAIL rr_write[%0d]: got wen=%b addr=%0d data=%0h expected 1/%0d/%0h", k, rf_wen, rf_waddr, rf_wdata, exp_addr, exp_data);
            end
        end
        pipe_wen = 2'b00;
        #1;
        checks++;
        if (pipe_ready !== 2'b00) begin
            errors++;
            $display("FAIL rr_idle_ready: got %b expected 00", pipe_ready);
        end
        tick();
        checks++;
        if (rf_wen !== 1'b0) begin
            errors++;
            $display("FAIL rr_idle_wen: got %b expected 0", rf_wen);
        end
    endtask

    task automatic test_grant_skip();
        apply_reset();
        pipe_wen      = 2'b01;
        pipe_waddr[0] = 5'd9;
        pipe_wdata[0] = 32'h11;
        tick();
        pipe_waddr[0] = 5'd10;
        pipe_wdata[0] = 32'h22;
        #1;
        checks++;
        if (pipe_ready !== 2'b01) begin
            errors++;
            $display("FAIL skip_ready: got %b expected 01", pipe_ready);
        end
        tick();
        checks++;
        if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd10, 32'h22}) begin
            errors++;
            $display("FAIL skip_write: got wen=%b addr=%0d data=%0h expected 1/10/22", rf_wen, rf_waddr, rf_wdata);
        end
        pipe_wen = 2'b11;
        #1;
        checks++;
        if (pipe_ready !== 2'b10) begin
            errors++;
            $display("FAIL skip_ptr: got %b expected 10", pipe_ready);
        end
    endtask

    task automatic test_x0();
        apply_reset();
        pipe_wen      = 2'b01;
        pipe_waddr[0] = 5'd0;
        pipe_wdata[0] = 32'hFFFF;
        #1;
        checks++;
        if (pipe_ready !== 2'b01) begin
            errors++;
            $display("FAIL x0_ready: got %b expected 01", pipe_ready);
        end
        tick();
        checks++;
        if (rf_wen !== 1'b0) begin
            errors++;
            $display("FAIL x0_wen: got %b expected 0", rf_wen);
        end
        pipe_wen = 2'b11;
        #1;
        checks++;
        if (pipe_ready !== 2'b10) begin
            errors++;
            $display("FAIL x0_consumed: got %b expected 10", pipe_ready);
        end
    endtask

`ifdef REGFILE_WB_ARB_SCOREBOARD_EN
    task automatic test_scoreboard();
        apply_reset();
        iss_val   = 1'b1;
        iss_wen   = 1'b1;
        iss_waddr = 5'd3;
        #1;
        checks++;
        if (iss_stall !== 1'b0) begin
            errors++;
            $display("FAIL sb_first_issue: got %b expected 0", iss_stall);
        end
        tick();
        iss_wen      = 1'b0;
        iss_raddr[0] = 5'd3;
        pipe_wen      = 2'b10;
        pipe_waddr[1] = 5'd3;
        pipe_wdata[1] = 32'h33;
        #1;
        checks++;
        if ({iss_stall, pipe_ready} !== {1'b1, 2'b10}) begin
            errors++;
            $display("FAIL sb_raw_stall: got stall=%b ready=%b expected 1/10", iss_stall, pipe_ready);
        end
        tick();
        pipe_wen = 2'b00;
        #1;
        checks++;
        if ({iss_stall, rf_wen, rf_waddr, rf_wdata} !== {1'b0, 1'b1, 5'd3, 32'h33}) begin
            errors++;
            $display("FAIL sb_release: got stall=%b wen=%b addr=%0d data=%0h expected 0/1/3/33", iss_stall, rf_wen, rf_waddr, rf_wdata);
        end
        iss_raddr[0] = 5'd0;
        iss_wen      = 1'b1;
        iss_waddr    = 5'd4;
        tick();
        iss_waddr    = 5'd4;
        iss_raddr[1] = 5'd0;
        #1;
        checks++;
        if (iss_stall !== 1'b1) begin
            errors++;
            $display("FAIL sb_waw_stall: got %b expected 1", iss_stall);
        end
        iss_wen      = 1'b0;
        iss_raddr[1] = 5'd4;
        #1;
        checks++;
        if (iss_stall !== 1'b1) begin
            errors++;
            $display("FAIL sb_raddr1_stall: got %b expected 1", iss_stall);
        end
        iss_val = 1'b0;
        #1;
        checks++;
        if (iss_stall !== 1'b0) begin
            errors++;
            $display("FAIL sb_no_val: got %b expected 0", iss_stall);
        end
    endtask

    task automatic test_collision();
        apply_reset();
        pipe_wen      = 2'b01;
        pipe_waddr[0] = 5'd7;
        pipe_wdata[0] = 32'h77;
        iss_val       = 1'b1;
        iss_wen       = 1'b1;
        iss_waddr     = 5'd7;
        #1;
        checks++;
        if ({iss_stall, pipe_ready} !== {1'b0, 2'b01}) begin
            errors++;
            $display("FAIL coll_same_cycle: got stall=%b ready=%b expected 0/01", iss_stall, pipe_ready);
        end
        tick();
        pipe_wen     = 2'b00;
        iss_wen      = 1'b0;
        iss_raddr[0] = 5'd7;
        #1;
        checks++;
        if (iss_stall !== 1'b1) begin
            errors++;
            $display("FAIL coll_pending: got %b expected 1", iss_stall);
        end
    endtask
`else
    task automatic test_scoreboard();
        apply_reset();
        iss_val   = 1'b1;
        iss_wen   = 1'b1;
        iss_waddr = 5'd3;
        tick();
        iss_raddr[0] = 5'd3;
        iss_raddr[1] = 5'd3;
        #1;
        checks++;
        if (iss_stall !== 1'b0) begin
            errors++;
            $display("FAIL nosb_stall_raw: got %b expected 0", iss_stall);
        end
        tick();
        checks++;
        if (iss_stall !== 1'b0) begin
            errors++;
            $display("FAIL nosb_stall_waw: got %b expected 0", iss_stall);
        end
    endtask

    task automatic test_collision();
        apply_reset();
        pipe_wen      = 2'b01;
        pipe_waddr[0] = 5'd7;
        pipe_wdata[0] = 32'h77;
        iss_val       = 1'b1;
        iss_wen       = 1'b1;
        iss_waddr     = 5'd7;
        tick();
        pipe_wen     = 2'b00;
        iss_raddr[0] = 5'd7;
        #1;
        checks++;
        if ({iss_stall, rf_wen, rf_waddr} !== {1'b0, 1'b1, 5'd7}) begin
            errors++;
            $display("FAIL nosb_collision: got stall=%b wen=%b addr=%0d expected 0/1/7", iss_stall, rf_wen, rf_waddr);
        end
    endtask
`endif

    initial begin
        rst = 1'b0;
        clear_inputs();
        test_reset();
        test_round_robin();
        test_grant_skip();
        test_x0();
        test_scoreboard();
        test_collision();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
